// File: rtl/u_core_pkg.sv
// Shared core constants and the writeback entry layout used by the
// register-file writeback delay pipeline.
package u_core_pkg;

  localparam int XLEN = 32;
  localparam int AW   = 5;

  typedef struct packed {
    logic            we;
    logic            pend;
    logic [AW-1:0]   a;
    logic [XLEN-1:0] d;
  } wb_entry_t;

endpackage

// File: rtl/u_wb_fwd_lookup.sv
// One forwarding lookup port: priority match of a source register against
// all in-flight writeback entries, youngest (index 0) first.
module u_wb_fwd_lookup #(
  parameter int XLEN  = u_core_pkg::XLEN,
  parameter int AW    = u_core_pkg::AW,
  parameter int DEPTH = 3
) (
  input  logic [DEPTH-1:0]      ent_we,
  input  logic [DEPTH-1:0]      ent_pend,
  input  logic [DEPTH*AW-1:0]   ent_a,
  input  logic [DEPTH*XLEN-1:0] ent_d,
  input  logic [AW-1:0]         lk_a,
  output logic                  hit,
  output logic                  pend,
  output logic [XLEN-1:0]       d
);

  // Walk oldest to youngest so the youngest match overwrites earlier ones.
  always_comb begin
    hit  = 1'b0;
    pend = 1'b0;
    d    = '0;
    for (int k = DEPTH - 1; k >= 0; k--) begin
      if (ent_we[k] && (lk_a != '0) && (ent_a[k*AW +: AW] == lk_a)) begin
        hit  = 1'b1;
        pend = ent_pend[k];
        d    = ent_pend[k] ? '0 : ent_d[k*XLEN +: XLEN];
      end
    end
  end

endmodule

// File: rtl/u_wb_fwd_pipe.sv
// Writeback delay pipeline with youngest-match forwarding and late-load fill.
// Optional perf counters are built when WBPIPE_PERF_EN is defined.
module u_wb_fwd_pipe #(
  parameter int XLEN  = u_core_pkg::XLEN,
  parameter int AW    = u_core_pkg::AW,
  parameter int DEPTH = 3,
  parameter int NRD   = 2
) (
  input  logic                clk,
  input  logic                rstn,
  input  logic                stall_i,
  input  logic                in_we,
  input  logic [AW-1:0]       in_a,
  input  logic [XLEN-1:0]     in_d,
  input  logic                in_pend,
  output logic                in_rdy,
  input  logic                ld_v,
  input  logic [XLEN-1:0]     ld_d,
  input  logic [NRD*AW-1:0]   lk_a,
  output logic [NRD-1:0]      lk_hit,
  output logic [NRD-1:0]      lk_pend,
  output logic [NRD*XLEN-1:0] lk_d,
  output logic                stall_o,
  output logic                rf_rd_e,
  output logic [AW-1:0]       rf_rd_a,
  output logic [XLEN-1:0]     rf_rd_i
`ifdef WBPIPE_PERF_EN
  ,
  output logic [XLEN-1:0]     perf_wr_cnt,
  output logic [XLEN-1:0]     perf_stl_cnt
`endif
);

  localparam int L = DEPTH - 1;

  typedef struct packed {
    logic            we;
    logic            pend;
    logic [AW-1:0]   a;
    logic [XLEN-1:0] d;
  } entry_t;

  entry_t stg_q [DEPTH];
  entry_t stg_d [DEPTH];
  logic   adv;

  assign stall_o = stg_q[L].we & stg_q[L].pend & ~ld_v;
  assign adv     = ~(stall_i | stall_o);
  assign in_rdy  = adv;

  always_comb begin
    logic fill_hit;
    int   fill_pos;
    fill_hit = 1'b0;
    fill_pos = 0;
    for (int k = 0; k < DEPTH; k++) begin
      if (stg_q[k].we && stg_q[k].pend) begin
        fill_hit = 1'b1;
        fill_pos = k;
      end
    end
    // Fill lands where the entry will sit after this edge; a retiring
    // entry shifts to DEPTH and its data leaves through rf_rd_i instead.
    if (adv) fill_pos = fill_pos + 1;

    if (adv) begin
      stg_d[0].we   = in_we & (in_a != '0);
      stg_d[0].pend = in_pend;
      stg_d[0].a    = in_a;
      stg_d[0].d    = in_d;
      for (int k = 1; k < DEPTH; k++) stg_d[k] = stg_q[k-1];
    end else begin
      for (int k = 0; k < DEPTH; k++) stg_d[k] = stg_q[k];
    end

    for (int k = 0; k < DEPTH; k++) begin
      if (ld_v && fill_hit && (fill_pos == k)) begin
        stg_d[k].d    = ld_d;
        stg_d[k].pend = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int k = 0; k < DEPTH; k++) stg_q[k] <= '0;
    end else begin
      for (int k = 0; k < DEPTH; k++) stg_q[k] <= stg_d[k];
    end
  end

  assign rf_rd_e = stg_q[L].we & adv;
  assign rf_rd_a = rf_rd_e ? stg_q[L].a : '0;
  assign rf_rd_i = rf_rd_e ? (stg_q[L].pend ? ld_d : stg_q[L].d) : '0;

  logic [DEPTH-1:0]      st_we;
  logic [DEPTH-1:0]      st_pend;
  logic [DEPTH*AW-1:0]   st_a;
  logic [DEPTH*XLEN-1:0] st_d;

  always_comb begin
    for (int k = 0; k < DEPTH; k++) begin
      st_we[k]              = stg_q[k].we;
      st_pend[k]            = stg_q[k].pend;
      st_a[k*AW +: AW]      = stg_q[k].a;
      st_d[k*XLEN +: XLEN]  = stg_q[k].d;
    end
  end

  for (genvar i = 0; i < NRD; i++) begin : g_lk
    u_wb_fwd_lookup #(
      .XLEN  (XLEN),
      .AW    (AW),
      .DEPTH (DEPTH)
    ) u_lk (
      .ent_we   (st_we),
      .ent_pend (st_pend),
      .ent_a    (st_a),
      .ent_d    (st_d),
      .lk_a     (lk_a[i*AW +: AW]),
      .hit      (lk_hit[i]),
      .pend     (lk_pend[i]),
      .d        (lk_d[i*XLEN +: XLEN])
    );
  end

`ifdef WBPIPE_PERF_EN
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      perf_wr_cnt  <= '0;
      perf_stl_cnt <= '0;
    end else begin
      if (rf_rd_e) perf_wr_cnt  <= perf_wr_cnt + 1'b1;
      if (stall_o) perf_stl_cnt <= perf_stl_cnt + 1'b1;
    end
  end
`endif

endmodule
